// File: rtl/fft_mag_ram_writer_if.sv
// Bundles the FFT output stream and the spectrum RAM write port shared by the
// FFT source / RAM side (master) and the magnitude writer (slave).
interface fft_mag_ram_writer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32
);
  logic                         s_valid;
  logic signed [IN_WIDTH-1:0]   s_re;
  logic signed [IN_WIDTH-1:0]   s_im;
  logic                         s_last;
  logic                         ram_wr_en;
  logic        [ADDR_WIDTH-1:0] ram_wr_addr;
  logic        [OUT_WIDTH-1:0]  ram_wr_data;

  modport master (
    output s_valid, s_re, s_im, s_last,
    input  ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  s_valid, s_re, s_im, s_last,
    output ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/fft_mag_ram_writer.sv
// Captures one bin-aligned FFT frame, computes re^2+im^2 per bin and drives the
// spectrum RAM write port, handshaking arm/done with scope control.
module fft_mag_ram_writer #(
  parameter int ADDR_WIDTH = 10,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                wr_clk_i,
  input  logic                wr_rst_n_i,
  input  logic                arm_i,
  input  logic                clr_i,
  fft_mag_ram_writer_if.slave bus,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic                ram_valid_o,
  output logic                len_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, FLUSH} state_t;

  state_t                        state_q;
  logic        [ADDR_WIDTH-1:0]  cnt_q;
  logic                          flush_q;
  logic                          frame_done_q;
  logic                          ram_valid_q;
  logic                          len_err_q;

  logic                          s1_valid_q;
  logic        [ADDR_WIDTH-1:0]  s1_addr_q;
  logic signed [2*IN_WIDTH-1:0]  re_sq_q;
  logic signed [2*IN_WIDTH-1:0]  im_sq_q;
  logic                          wr_en_q;
  logic        [ADDR_WIDTH-1:0]  addr_q;
  logic        [OUT_WIDTH-1:0]   data_q;

  logic signed [2*IN_WIDTH-1:0]  re_ext_d;
  logic signed [2*IN_WIDTH-1:0]  im_ext_d;
  logic signed [2*IN_WIDTH-1:0]  re_sq_d;
  logic signed [2*IN_WIDTH-1:0]  im_sq_d;
  logic        [OUT_WIDTH-1:0]   sum_d;
  logic                          take_d;
  logic                          cnt_max_d;
  logic                          frame_end_d;

  assign take_d      = (state_q == CAPTURE) && bus.s_valid;
  assign cnt_max_d   = (cnt_q == {ADDR_WIDTH{1'b1}});
  assign frame_end_d = take_d && (cnt_max_d || bus.s_last);

  // Squares are non-negative and at most 2**30, so their sum always fits 32 bits.
  assign re_ext_d = {{IN_WIDTH{bus.s_re[IN_WIDTH-1]}}, bus.s_re};
  assign im_ext_d = {{IN_WIDTH{bus.s_im[IN_WIDTH-1]}}, bus.s_im};
  assign re_sq_d  = re_ext_d * re_ext_d;
  assign im_sq_d  = im_ext_d * im_ext_d;
  assign sum_d    = OUT_WIDTH'($unsigned(re_sq_q)) + OUT_WIDTH'($unsigned(im_sq_q));

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ram_valid_q  <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (clr_i) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        flush_q     <= 1'b0;
        ram_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (arm_i) begin
              state_q     <= WAIT_SOF;
              ram_valid_q <= 1'b0;
              len_err_q   <= 1'b0;
            end
          end
          WAIT_SOF: begin
            if (bus.s_valid && bus.s_last) begin
              state_q <= CAPTURE;
              cnt_q   <= '0;
            end
          end
          CAPTURE: begin
            if (take_d) begin
              cnt_q <= cnt_q + 1'b1;
              if (frame_end_d) begin
                state_q   <= FLUSH;
                flush_q   <= 1'b0;
                len_err_q <= !(cnt_max_d && bus.s_last);
              end
            end
          end
          FLUSH: begin
            // Two cycles drain the pipeline so done follows the final write.
            flush_q <= 1'b1;
            if (flush_q) begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
              ram_valid_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      re_sq_q    <= '0;
      im_sq_q    <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else if (clr_i) begin
      s1_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      s1_valid_q <= take_d;
      if (take_d) begin
        s1_addr_q <= cnt_q;
        re_sq_q   <= re_sq_d;
        im_sq_q   <= im_sq_d;
      end
      wr_en_q <= s1_valid_q;
      if (s1_valid_q) begin
        addr_q <= s1_addr_q;
        data_q <= sum_d;
      end
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = addr_q;
  assign bus.ram_wr_data = data_q;
  assign busy_o          = (state_q != IDLE);
  assign frame_done_o    = frame_done_q;
  assign ram_valid_o     = ram_valid_q;
  assign len_err_o       = len_err_q;

endmodule
